aes_ctrl: RTL
=============

AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 3: cycles dp_init is held high before each encryption.
REQ-002 Parameter ROUND_CYCLES, default 4: datapath cycles per AES round.
REQ-003 Parameter NUM_ROUNDS, default 10: AES-128 round count; dp_rnd runs 1..NUM_ROUNDS.
REQ-004 Parameter TIMEOUT, default 64: maximum cycles waited for dp_done after the last round.
REQ-005 Ports (name  direction  width  meaning) SHALL be as follows:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- plain_in  in  128  plaintext, sampled on accept.
- key_in  in  128  key, sampled on accept.
- ready  out  1  idle and able to accept start.
- busy  out  1  encryption in progress (the inverse of ready).
- dp_init  out  1  datapath init.
- dp_ctrl1, dp_ctrl2, dp_ctrl3  out  1 each  datapath load strobes.
- dp_rnd  out  4  round number to the datapath.
- dp_plain_text  out  128  registered plaintext to the datapath.
- dp_key  out  128  registered key to the datapath.
- dp_done  in  1  datapath completion.
- dp_cipher  in  128  datapath cipher_text.
- cipher_out  out  128  captured ciphertext.
- valid  out  1  one-cycle pulse; cipher_out is valid.
- err  out  1  one-cycle pulse on timeout.

Function
REQ-006 The FSM states SHALL be IDLE, INIT, LOAD, RUN, WAIT, OUT.
REQ-007 In IDLE, ready=1; start=1 SHALL register plain_in/key_in into dp_plain_text/dp_key and move to INIT on the next edge.
REQ-008 INIT SHALL drive dp_init=1 for exactly INIT_CYCLES cycles, then go to LOAD.
REQ-009 LOAD SHALL last one cycle with dp_ctrl1=dp_ctrl2=dp_ctrl3=1 and dp_rnd=1, then go to RUN.
REQ-010 Outside LOAD, dp_ctrl1..3 SHALL be 0; outside INIT, dp_init SHALL be 0.
REQ-011 RUN SHALL hold each dp_rnd value for ROUND_CYCLES cycles, incrementing it from 1 to NUM_ROUNDS.
REQ-012 After NUM_ROUNDS rounds (ROUND_CYCLES*NUM_ROUNDS cycles in RUN), the FSM SHALL go to WAIT; dp_rnd holds NUM_ROUNDS in WAIT.
REQ-013 In WAIT, dp_done=1 SHALL capture dp_cipher into cipher_out and move to OUT.
REQ-014 In WAIT, if TIMEOUT cycles elapse without dp_done, the block SHALL pulse err for one cycle, leave cipher_out unchanged, and return to IDLE.
REQ-015 OUT SHALL last one cycle with valid=1, then go to IDLE.
REQ-016 Minimum accept-to-valid latency SHALL be 1+INIT_CYCLES+1+ROUND_CYCLES*NUM_ROUNDS+1 cycles after the start edge, plus the WAIT cycles up to and including the dp_done cycle.
REQ-017 start while busy SHALL be ignored, with no queuing.
REQ-018 start asserted in the same cycle as valid SHALL be ignored; ready is 0 in OUT.
REQ-019 dp_done outside WAIT SHALL be ignored.
REQ-020 dp_plain_text and dp_key SHALL remain stable from accept until the next accept.
REQ-021 The round counter SHALL be 4 bits and the cycle and timeout counters $clog2-sized; no counter SHALL wrap within a valid operation.

Reset
REQ-022 rst=1 at any clock edge, including mid-operation, SHALL force IDLE and abort any encryption without asserting valid or err.
REQ-023 Reset values SHALL be: ready=1, busy=0, valid=0, err=0, dp_init=0, dp_ctrl1..3=0, dp_rnd=0, cipher_out=0, dp_plain_text=0, dp_key=0, all counters 0.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 Package aes_pkg SHALL hold the FSM state typedef, the NUM_ROUNDS default, and the AES block width constant (128).
REQ-026 One sub-module, aes_rnd_cnt, SHALL implement the round counter and cycle-in-round counter, with outputs rnd and last_round.

Verification
REQ-027 Basic: rst, then start with plain_in=128'h12233445 and key_in=128'hA3928674; a stub dp_done fires 5 cycles into WAIT with dp_cipher=128'hDEADBEEF -> valid once at the REQ-016 cycle and cipher_out=128'hDEADBEEF.
REQ-028 Sequencing: check dp_init high for exactly 3 cycles, one LOAD cycle with all ctrl high and dp_rnd=1, then dp_rnd 1..10 at 4 cycles each.
REQ-029 Busy: start pulses during RUN -> ignored; exactly one valid; dp_plain_text unchanged.
REQ-030 Timeout: dp_done held 0 -> err pulse 64 cycles after WAIT entry, no valid, ready=1 on the next cycle.
REQ-031 Mid-run reset: rst for one cycle during round 6 -> all outputs at reset values the next cycle; a new start completes normally.
REQ-032 Back-to-back: start asserted in the OUT cycle -> ignored; start the cycle after -> accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 datapath controller.
package aes_pkg;

    localparam int AES_BLK_W      = 128;
    localparam int NUM_ROUNDS_DEF = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        WAIT = 3'd4,
        OUT  = 3'd5
    } aes_state_e;

    // Counter width for a modulus n; a 1-cycle count still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_rnd_cnt.sv
// Round counter plus cycle-in-round counter for the AES controller.
// rnd is forced to 1 on load, advances every ROUND_CYCLES cycles while en is
// high, and saturates at NUM_ROUNDS so it can be held through WAIT.
module aes_rnd_cnt
    import aes_pkg::*;
#(
    parameter int ROUND_CYCLES = 4,
    parameter int NUM_ROUNDS   = NUM_ROUNDS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] rnd,
    output logic       last_round
);

    localparam int              CYC_W    = cnt_w(ROUND_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ROUND_CYCLES - 1);
    localparam logic [3:0]       RND_LAST = 4'(NUM_ROUNDS);

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [3:0]       rnd_q, rnd_d;

    // Next-state for the round and cycle-in-round counters.
    always_comb begin
        cyc_d = cyc_q;
        rnd_d = rnd_q;
        if (load) begin
            rnd_d = 4'd1;
            cyc_d = '0;
        end else if (en) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (rnd_q != RND_LAST) begin
                    rnd_d = rnd_q + 4'd1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end else if (clr) begin
            rnd_d = '0;
            cyc_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            rnd_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            rnd_q <= rnd_d;
        end
    end

    assign rnd        = rnd_q;
    // High during the final cycle of the final round.
    assign last_round = en && (rnd_q == RND_LAST) && (cyc_q == CYC_LAST);

endmodule

// File: rtl/aes_ctrl.sv
// Sequencing controller for an iterative AES-128 datapath: latches the
// operands, walks the datapath through init/load/rounds, then waits (with a
// timeout) for the datapath to report completion and captures the result.
module aes_ctrl
    import aes_pkg::*;
#(
    parameter int INIT_CYCLES  = 3,
    parameter int ROUND_CYCLES = 4,
    parameter int NUM_ROUNDS   = NUM_ROUNDS_DEF,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_BLK_W-1:0] plain_in,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 dp_init,
    output logic                 dp_ctrl1,
    output logic                 dp_ctrl2,
    output logic                 dp_ctrl3,
    output logic [3:0]           dp_rnd,
    output logic [AES_BLK_W-1:0] dp_plain_text,
    output logic [AES_BLK_W-1:0] dp_key,
    input  logic                 dp_done,
    input  logic [AES_BLK_W-1:0] dp_cipher,
    output logic [AES_BLK_W-1:0] cipher_out,
    output logic                 valid,
    output logic                 err
);

    localparam int                INIT_W    = cnt_w(INIT_CYCLES);
    localparam int                TMO_W     = cnt_w(TIMEOUT);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    aes_state_e           state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [AES_BLK_W-1:0] plain_q, plain_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] cipher_q, cipher_d;
    logic                 err_q, err_d;

    logic                 rnd_load;
    logic                 rnd_en;
    logic                 rnd_clr;
    logic                 last_round;
    logic [3:0]           rnd;

    // FSM next-state, operand capture, init/timeout counting.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        tmo_cnt_d  = '0;
        plain_d    = plain_q;
        key_d      = key_q;
        cipher_d   = cipher_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                init_cnt_d = '0;
                if (start) begin
                    plain_d = plain_in;
                    key_d   = key_in;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    state_d    = LOAD;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (last_round) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Completion wins over a timeout expiring in the same cycle.
                if (dp_done) begin
                    cipher_d = dp_cipher;
                    state_d  = OUT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and data registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            plain_q    <= '0;
            key_q      <= '0;
            cipher_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            plain_q    <= plain_d;
            key_q      <= key_d;
            cipher_q   <= cipher_d;
            err_q      <= err_d;
        end
    end

    // Round counter: primed to 1 as LOAD is entered, stepped through RUN,
    // held through WAIT/OUT and cleared whenever the FSM heads to IDLE.
    assign rnd_load = (state_q == INIT) && (init_cnt_q == INIT_LAST);
    assign rnd_en   = (state_q == RUN);
    assign rnd_clr  = (state_d == IDLE);

    aes_rnd_cnt #(
        .ROUND_CYCLES (ROUND_CYCLES),
        .NUM_ROUNDS   (NUM_ROUNDS)
    ) u_rnd_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (rnd_load),
        .en         (rnd_en),
        .clr        (rnd_clr),
        .rnd        (rnd),
        .last_round (last_round)
    );

    assign ready         = (state_q == IDLE);
    assign busy          = ~ready;
    assign dp_init       = (state_q == INIT);
    assign dp_ctrl1      = (state_q == LOAD);
    assign dp_ctrl2      = (state_q == LOAD);
    assign dp_ctrl3      = (state_q == LOAD);
    assign dp_rnd        = rnd;
    assign dp_plain_text = plain_q;
    assign dp_key        = key_q;
    assign cipher_out    = cipher_q;
    assign valid         = (state_q == OUT);
    assign err           = err_q;

endmodule
